// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO: pointer sizing and handshake classification
// used by the line trace.
package stream_fifo_pkg;

    // Kind of activity seen on one val/rdy stream in a cycle.
    typedef enum logic [1:0] {
        XFER_IDLE  = 2'd0,
        XFER_STALL = 2'd1,
        XFER_FIRE  = 2'd2
    } xfer_e;

    // Pointer width for a given depth; a single-entry FIFO still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    // Classify a stream handshake for tracing.
    function automatic xfer_e classify_xfer(input logic val, input logic rdy);
        xfer_e k;
        if (val && rdy) begin
            k = XFER_FIRE;
        end else if (val) begin
            k = XFER_STALL;
        end else begin
            k = XFER_IDLE;
        end
        return k;
    endfunction

endpackage

// File: rtl/stream_fifo_storage.sv
// Entry storage for stream_fifo: one synchronous write port, one combinational
// read port, no reset (contents are only meaningful between the pointers).
module stream_fifo_storage
    import stream_fifo_pkg::*;
#(
    parameter type         t_msg   = logic [31:0],
    parameter int unsigned p_depth = 4,
    parameter int unsigned p_aw    = ptr_width(p_depth)
) (
    input  logic            clk,
    input  logic            wen,
    input  logic [p_aw-1:0] waddr,
    input  t_msg            wdata,
    input  logic [p_aw-1:0] raddr,
    output t_msg            rdata
);

    t_msg mem_q [p_depth];

    // Write the incoming entry at the tail slot.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Val/rdy message queue: decouples a producer from a back-pressuring consumer.
// In-order, no bypass, and istream_rdy never looks at ostream_rdy.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter type         t_msg   = logic [31:0],
    parameter int unsigned p_depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  t_msg                         istream_msg,
    input  logic                         istream_val,
    output logic                         istream_rdy,
    output t_msg                         ostream_msg,
    output logic                         ostream_val,
    input  logic                         ostream_rdy,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int unsigned AW = ptr_width(p_depth);
    localparam int unsigned CW = $clog2(p_depth + 1);

    localparam logic [AW-1:0] LAST_PTR   = AW'(p_depth - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(p_depth);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq_s;
    logic          deq_s;

    // Advance a pointer, wrapping explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == LAST_PTR) begin
            n = {AW{1'b0}};
        end else begin
            n = p + AW'(1);
        end
        return n;
    endfunction

    // Ready/valid come only from occupancy and reset, so full means full even if
    // the consumer is draining this same cycle.
    assign istream_rdy = !rst && (count_q != FULL_COUNT);
    assign ostream_val = !rst && (count_q != {CW{1'b0}});
    assign enq_s       = istream_val && istream_rdy;
    assign deq_s       = ostream_val && ostream_rdy;
    assign count       = count_q;

    stream_fifo_storage #(
        .t_msg   (t_msg),
        .p_depth (p_depth),
        .p_aw    (AW)
    ) u_storage (
        .clk   (clk),
        .wen   (enq_s),
        .waddr (tail_q),
        .wdata (istream_msg),
        .raddr (head_q),
        .rdata (ostream_msg)
    );

    // Next pointers and occupancy from the two handshakes.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (deq_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Line trace: input side, occupancy, output side ('#' stalled, '.' idle).
    function automatic string trace();
        string s_in;
        string s_out;
        case (classify_xfer(istream_val, istream_rdy))
            XFER_FIRE:  s_in = $sformatf("%h", istream_msg);
            XFER_STALL: s_in = "#";
            XFER_IDLE:  s_in = ".";
            default:    s_in = "?";
        endcase
        case (classify_xfer(ostream_val, ostream_rdy))
            XFER_FIRE:  s_out = $sformatf("%h", ostream_msg);
            XFER_STALL: s_out = "#";
            XFER_IDLE:  s_out = ".";
            default:    s_out = "?";
        endcase
        return $sformatf("%s(%0d)%s", s_in, count_q, s_out);
    endfunction

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (depth 4, 32-bit messages) with a queue-based reference model.
module tb_stream_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] istream_msg;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] ostream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [2:0]  count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl_q [$];

    stream_fifo #(.t_msg(logic [31:0]), .p_depth(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Called at a negedge with inputs already driven: records which handshakes fire
    // at the coming posedge, then returns at the following negedge.
    task automatic clock_cycle(output bit enq, output bit deq, output logic [31:0] dmsg);
        #1;
        enq  = istream_val && istream_rdy;
        deq  = ostream_val && ostream_rdy;
        dmsg = ostream_msg;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; istream_val = 1'b0; ostream_rdy = 1'b0; istream_msg = 32'h0;
        @(posedge clk); @(negedge clk);
        total++; if (istream_rdy !== 1'b0) begin bad++; $display("FAIL reset_irdy: got %b want 0", istream_rdy); end
        total++; if (ostream_val !== 1'b0) begin bad++; $display("FAIL reset_oval: got %b want 0", ostream_val); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL idle_count: got %0d want 0", count); end
        total++; if (ostream_val !== 1'b0) begin bad++; $display("FAIL idle_oval: got %b want 0", ostream_val); end
        total++; if (istream_rdy !== 1'b1) begin bad++; $display("FAIL idle_irdy: got %b want 1", istream_rdy); end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit e, d; logic [31:0] dm, ex;
        istream_msg = 32'hDEADBEEF; istream_val = 1'b1; ostream_rdy = 1'b1;
        clock_cycle(e, d, dm);
        total++; if (e !== 1'b1 || d !== 1'b0) begin bad++; $display("FAIL single_enq: got enq=%b deq=%b want 1 0", e, d); end
        if (e) mdl_q.push_back(istream_msg);
        istream_val = 1'b0;
        total++; if (ostream_val !== 1'b1 || ostream_msg !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_visible: got val=%b msg=%h want 1 deadbeef", ostream_val, ostream_msg); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", count); end
        clock_cycle(e, d, dm);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL single_deq: got %b want 1", d); end
        if (d && mdl_q.size() > 0) begin
            ex = mdl_q.pop_front();
            total++; if (dm !== ex) begin bad++; $display("FAIL single_msg: got %h want %h", dm, ex); end
        end
        total++; if (count !== 3'd0 || ostream_val !== 1'b0) begin
            bad++; $display("FAIL single_drained: got count=%0d val=%b want 0 0", count, ostream_val); end
    endtask

    task automatic test_fill_backpressure();
        bit e, d; logic [31:0] dm, ex; int recv;
        ostream_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            istream_msg = 32'(i); istream_val = 1'b1;
            clock_cycle(e, d, dm);
            total++; if (e !== bit'(i <= 4)) begin bad++; $display("FAIL fill_accept%0d: got %b want %b", i, e, i <= 4); end
            if (e) mdl_q.push_back(istream_msg);
        end
        total++; if (count !== 3'd4 || istream_rdy !== 1'b0) begin
            bad++; $display("FAIL fill_full: got count=%0d irdy=%b want 4 0", count, istream_rdy); end
        ostream_rdy = 1'b1;
        recv = 0;
        for (int c = 0; c < 20 && (istream_val || mdl_q.size() > 0); c++) begin
            clock_cycle(e, d, dm);
            if (d) begin
                recv++;
                total++;
                if (mdl_q.size() == 0) begin bad++; $display("FAIL fill_order: got %h want nothing", dm); end
                else begin
                    ex = mdl_q.pop_front();
                    if (dm !== ex) begin bad++; $display("FAIL fill_order: got %h want %h", dm, ex); end
                end
            end
            if (e) begin mdl_q.push_back(istream_msg); istream_val = 1'b0; end
        end
        total++; if (recv != 5) begin bad++; $display("FAIL fill_recv: got %0d want 5", recv); end
    endtask

    task automatic test_full_simul_deq();
        bit e, d; logic [31:0] dm, ex;
        ostream_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            istream_msg = $urandom; istream_val = 1'b1;
            clock_cycle(e, d, dm);
            if (e) mdl_q.push_back(istream_msg);
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count4: got %0d want 4", count); end
        istream_msg = $urandom; istream_val = 1'b1; ostream_rdy = 1'b1;
        clock_cycle(e, d, dm);
        total++; if (e !== 1'b0 || d !== 1'b1) begin bad++; $display("FAIL full_simul: got enq=%b deq=%b want 0 1", e, d); end
        if (d && mdl_q.size() > 0) begin
            ex = mdl_q.pop_front();
            total++; if (dm !== ex) begin bad++; $display("FAIL full_simul_msg: got %h want %h", dm, ex); end
        end
        if (e) mdl_q.push_back(istream_msg);
        total++; if (count !== 3'd3 || istream_rdy !== 1'b1) begin
            bad++; $display("FAIL full_after_deq: got count=%0d irdy=%b want 3 1", count, istream_rdy); end
        ostream_rdy = 1'b0;
        clock_cycle(e, d, dm);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL full_reenq: got %b want 1", e); end
        if (e) mdl_q.push_back(istream_msg);
        istream_val = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d want 4", count); end
        ostream_rdy = 1'b1;
        for (int c = 0; c < 10 && mdl_q.size() > 0; c++) begin
            clock_cycle(e, d, dm);
            if (d) begin
                ex = mdl_q.pop_front();
                total++; if (dm !== ex) begin bad++; $display("FAIL full_drain: got %h want %h", dm, ex); end
            end
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_empty: got %0d want 0", count); end
    endtask

    task automatic test_streaming();
        bit e, d; logic [31:0] dm, ex;
        int sent, recv, src_wait, sink_wait;
        sent = 0; recv = 0;
        src_wait = $urandom_range(3, 0); sink_wait = $urandom_range(3, 0);
        istream_val = 1'b0;
        for (int c = 0; c < 2000 && recv < 100; c++) begin
            if (!istream_val && sent < 100) begin
                if (src_wait == 0) begin istream_msg = $urandom; istream_val = 1'b1; end
                else src_wait--;
            end
            ostream_rdy = (sink_wait == 0);
            clock_cycle(e, d, dm);
            if (d) begin
                recv++;
                sink_wait = $urandom_range(3, 0);
                total++;
                if (mdl_q.size() == 0) begin bad++; $display("FAIL stream_msg: got %h want nothing", dm); end
                else begin
                    ex = mdl_q.pop_front();
                    if (dm !== ex) begin bad++; $display("FAIL stream_msg: got %h want %h", dm, ex); end
                end
            end else if (sink_wait > 0) begin
                sink_wait--;
            end
            if (e) begin
                mdl_q.push_back(istream_msg); sent++;
                istream_val = 1'b0; src_wait = $urandom_range(3, 0);
            end
            total++;
            if (32'(count) != 32'(mdl_q.size()) || count > 3'd4) begin
                bad++; $display("FAIL stream_count: got %0d want %0d", count, mdl_q.size()); end
        end
        istream_val = 1'b0;
        total++; if (recv != 100) begin bad++; $display("FAIL stream_recv: got %0d want 100", recv); end
    endtask

    task automatic test_reset_mid();
        bit e, d; logic [31:0] dm, ex;
        ostream_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            istream_msg = $urandom; istream_val = 1'b1;
            clock_cycle(e, d, dm);
            if (e) mdl_q.push_back(istream_msg);
        end
        istream_val = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_count3: got %0d want 3", count); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        #1;
        total++; if (count !== 3'd0 || ostream_val !== 1'b0) begin
            bad++; $display("FAIL mid_flushed: got count=%0d val=%b want 0 0", count, ostream_val); end
        @(negedge clk);
        istream_msg = 32'hA5; istream_val = 1'b1; ostream_rdy = 1'b1;
        clock_cycle(e, d, dm);
        total++; if (e !== 1'b1 || d !== 1'b0) begin bad++; $display("FAIL mid_enq: got enq=%b deq=%b want 1 0", e, d); end
        if (e) mdl_q.push_back(istream_msg);
        istream_val = 1'b0;
        clock_cycle(e, d, dm);
        total++; if (d !== 1'b1 || dm !== 32'hA5) begin bad++; $display("FAIL mid_first: got deq=%b msg=%h want 1 a5", d, dm); end
        if (d && mdl_q.size() > 0) ex = mdl_q.pop_front();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_empty: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_full_simul_deq();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
